// File: rtl/cp0_unit.sv
// -----------------------------------------------------------------------------
// cp0_unit -- Coprocessor-0 interrupt/exception receiver.
//
// Masks the six hardware interrupt lines with SR.IM, merges them with the
// synchronous exception code from the pipeline and raises a single IntReq
// in the same cycle. On an accepted request it records EPC, BD and ExcCode
// and sets EXL. It also serves mfc0 reads (combinational), mtc0 writes and
// eret (EXL clear). All state changes commit on the rising clk edge.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   A1         mfc0 read register number
//   A2         mtc0 write register number
//   DIn        mtc0 write data
//   We         mtc0 write enable
//   PC         PC of the instruction in M stage
//   BDIn       M-stage instruction sits in a branch delay slot
//   ExcIn      synchronous exception code, 0 = none
//   HWInt      hardware interrupt lines [7:2], level-sensitive
//   EXLClr     eret in M stage
//   IntReq     take interrupt/exception now (combinational)
//   EPCOut     current EPC
//   HandlerPC  constant exception entry address
//   DOut       mfc0 read data (combinational)
// -----------------------------------------------------------------------------
module cp0_unit #(
   parameter logic [31:0] PRID         = 32'h2017_1213,
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        We,
   input  logic [31:0] PC,
   input  logic        BDIn,
   input  logic [4:0]  ExcIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        IntReq,
   output logic [31:0] EPCOut,
   output logic [31:0] HandlerPC,
   output logic [31:0] DOut
);

   // SR fields
   logic [5:0]  im_reg;
   logic        exl_reg;
   logic        ie_reg;
   // Cause fields
   logic        bd_reg;
   logic [5:0]  ip_reg;
   logic [4:0]  exc_code_reg;
   // EPC is word aligned; only the upper 30 bits are stored
   logic [29:0] epc_reg;

   logic [5:0]  masked;
   logic        int_pend;
   logic        exc_pend;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   // PC[1:0] never reaches EPC
   logic        unused_pc_bits;
   assign unused_pc_bits = ^PC[1:0];

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_mask
         assign masked[gi] = HWInt[gi] & im_reg[gi];
      end
   endgenerate

   assign int_pend = (|masked) & ie_reg & ~exl_reg;
   assign exc_pend = (ExcIn != 5'd0) & ~exl_reg;
   // Held low while reset is asserted so the pipeline never sees a request
   // during reset, whatever ExcIn is doing.
   assign IntReq   = (int_pend | exc_pend) & clr;

   assign sr_word    = {16'b0, im_reg, 8'b0, exl_reg, ie_reg};
   assign cause_word = {bd_reg, 15'b0, ip_reg, 3'b0, exc_code_reg, 2'b00};
   assign EPCOut     = {epc_reg, 2'b00};
   assign HandlerPC  = HANDLER_ADDR;

   // mfc0 reads current state; a same-cycle mtc0 is not forwarded.
   always_comb begin
      DOut = 32'h0;
      case (A1)
         5'd12:   DOut = sr_word;
         5'd13:   DOut = cause_word;
         5'd14:   DOut = EPCOut;
         5'd15:   DOut = PRID;
         default: DOut = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         im_reg       <= 6'd0;
         exl_reg      <= 1'b0;
         ie_reg       <= 1'b0;
         bd_reg       <= 1'b0;
         ip_reg       <= 6'd0;
         exc_code_reg <= 5'd0;
         epc_reg      <= 30'd0;
      end else begin
         // IP mirrors the raw lines with one cycle of latency, always.
         ip_reg <= HWInt;
         if (IntReq) begin
            // Entry: any concurrent mtc0 is dropped. EXLClr cannot be
            // meaningful here because IntReq implies EXL is already 0.
            exl_reg      <= 1'b1;
            bd_reg       <= BDIn;
            exc_code_reg <= int_pend ? 5'd0 : ExcIn;
            // Delay-slot instructions restart at the branch (PC-4);
            // subtraction wraps naturally at 30 bits.
            epc_reg      <= PC[31:2] - {29'd0, BDIn};
         end else begin
            if (We && (A2 == 5'd12)) begin
               im_reg  <= DIn[15:10];
               ie_reg  <= DIn[0];
               // eret overrides only the EXL bit of a same-cycle SR write
               exl_reg <= DIn[1] & ~EXLClr;
            end else if (EXLClr) begin
               exl_reg <= 1'b0;
            end
            if (We && (A2 == 5'd14)) begin
               epc_reg <= DIn[31:2];
            end
         end
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_unit -- self-checking bench for cp0_unit.
//
// Keeps the architectural view of SR, Cause and EPC as whole 32-bit words and
// predicts IntReq, DOut and EPCOut each cycle from those words. Directed
// scenarios cover reset, masking, delay slots, priority, eret and register
// access; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_cp0_unit;

   localparam logic [31:0] PRID_C    = 32'h2017_1213;
   localparam logic [31:0] HANDLER_C = 32'h0000_4180;

   logic        clk;
   logic        clr;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] DIn;
   logic        We;
   logic [31:0] PC;
   logic        BDIn;
   logic [4:0]  ExcIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic        IntReq;
   logic [31:0] EPCOut;
   logic [31:0] HandlerPC;
   logic [31:0] DOut;

   int tests;
   int fails;

   // reference architectural state
   logic [31:0] m_sr;
   logic [31:0] m_cause;
   logic [31:0] m_epc;

   cp0_unit dut (
      .clk       (clk),
      .clr       (clr),
      .A1        (A1),
      .A2        (A2),
      .DIn       (DIn),
      .We        (We),
      .PC        (PC),
      .BDIn      (BDIn),
      .ExcIn     (ExcIn),
      .HWInt     (HWInt),
      .EXLClr    (EXLClr),
      .IntReq    (IntReq),
      .EPCOut    (EPCOut),
      .HandlerPC (HandlerPC),
      .DOut      (DOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID_C;
         default: return 32'h0;
      endcase
   endfunction

   // interrupt pending: some enabled line is high, IE set, not at exception level
   function automatic logic model_int(input logic [5:0] hw);
      return (m_sr[1] == 1'b0) && (m_sr[0] == 1'b1) && ((hw & m_sr[15:10]) != 6'd0);
   endfunction

   function automatic logic model_req(input logic [5:0] hw, input logic [4:0] exc);
      return model_int(hw) || ((m_sr[1] == 1'b0) && (exc != 5'd0));
   endfunction

   task automatic model_reset();
      m_sr    = 32'h0;
      m_cause = 32'h0;
      m_epc   = 32'h0;
   endtask

   // One clock cycle: drive inputs just after the falling edge, check the
   // combinational outputs, let the rising edge happen, then advance the model.
   task automatic cyc(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] din,
                      input logic we, input logic [31:0] pc, input logic bd,
                      input logic [4:0] exc, input logic [5:0] hw, input logic eret);
      logic        take;
      logic        intr;
      logic [31:0] n_sr;
      logic [31:0] n_cause;
      logic [31:0] n_epc;
      A1 = a1; A2 = a2; DIn = din; We = we; PC = pc; BDIn = bd;
      ExcIn = exc; HWInt = hw; EXLClr = eret;
      #1;
      take = model_req(hw, exc);
      intr = model_int(hw);
      chk("intreq", {31'd0, IntReq}, {31'd0, take});
      chk("dout", DOut, model_read(a1));
      chk("epcout", EPCOut, m_epc);
      chk("handler", HandlerPC, HANDLER_C);
      $display("[TB] t=%0t a1=%0d a2=%0d we=%0b din=%h pc=%h bd=%0b exc=%0d hw=%b eret=%0b req=%0b dout=%h",
               $time, a1, a2, we, din, pc, bd, exc, hw, eret, IntReq, DOut);
      n_sr    = m_sr;
      n_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
      n_epc   = m_epc;
      if (take) begin
         n_sr    = m_sr | 32'h2;
         n_cause = (n_cause & ~32'h8000_007C) | (32'(bd) << 31)
                   | (intr ? 32'h0 : (32'(exc) << 2));
         n_epc   = (pc & ~32'h3) - (bd ? 32'd4 : 32'd0);
      end else begin
         if (we && a2 == 5'd12) n_sr = din & 32'h0000_FC03;
         if (eret) n_sr = n_sr & ~32'h2;
         if (we && a2 == 5'd14) n_epc = din & ~32'h3;
      end
      @(posedge clk);
      m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
      @(negedge clk);
   endtask

   // mfc0 peek between cycles (no clock edge)
   task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
      A1 = a;
      #1;
      chk(name, DOut, exp);
   endtask

   initial begin
      tests = 0; fails = 0;
      clr = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; We = 1'b0; PC = 32'h0;
      BDIn = 1'b0; ExcIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_intreq", {31'd0, IntReq}, 32'd0);
      chk("rst_epcout", EPCOut, 32'h0);
      chk("rst_handler", HandlerPC, HANDLER_C);
      rd("rst_sr", 5'd12, 32'h0);
      rd("rst_cause", 5'd13, 32'h0);
      rd("rst_epc", 5'd14, 32'h0);
      clr = 1'b1;
      @(negedge clk);

      // masked timer IRQ
      cyc(5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'h3000, 1'b0, 5'd0, 6'b000000, 1'b0);
      cyc(5'd12, 5'd0, 32'h0, 1'b0, 32'h3010, 1'b0, 5'd0, 6'b000001, 1'b0);
      rd("t2_sr", 5'd12, 32'h0000_0403);
      rd("t2_epc", 5'd14, 32'h0000_3010);
      rd("t2_cause", 5'd13, 32'h0000_0400);
      chk("t2_drop", {31'd0, IntReq}, 32'd0);

      // delay slot plus masking
      cyc(5'd12, 5'd12, 32'h0000_0801, 1'b1, 32'h3014, 1'b0, 5'd0, 6'b000001, 1'b0);
      cyc(5'd12, 5'd0, 32'h0, 1'b0, 32'h3018, 1'b0, 5'd0, 6'b000001, 1'b0);
      chk("t3_masked", {31'd0, IntReq}, 32'd0);
      cyc(5'd13, 5'd0, 32'h0, 1'b0, 32'h3024, 1'b1, 5'd0, 6'b000010, 1'b0);
      rd("t3_epc", 5'd14, 32'h0000_3020);
      rd("t3_cause", 5'd13, 32'h8000_0800);

      // priority and mtc0 collision
      cyc(5'd12, 5'd12, 32'h0000_0801, 1'b1, 32'h3030, 1'b0, 5'd0, 6'b000000, 1'b0);
      cyc(5'd14, 5'd14, 32'hDEAD_BEEC, 1'b1, 32'h3040, 1'b0, 5'd12, 6'b000010, 1'b0);
      rd("t4_epc", 5'd14, 32'h0000_3040);
      rd("t4_cause", 5'd13, 32'h0000_0800);
      cyc(5'd12, 5'd12, 32'h0000_0801, 1'b1, 32'h3044, 1'b0, 5'd0, 6'b000000, 1'b0);
      cyc(5'd13, 5'd0, 32'h0, 1'b0, 32'h3050, 1'b0, 5'd12, 6'b000000, 1'b0);
      rd("t4_exccode", 5'd13, 32'h0000_0030);
      rd("t4_epc2", 5'd14, 32'h0000_3050);

      // eret
      cyc(5'd12, 5'd0, 32'h0, 1'b0, 32'h3054, 1'b0, 5'd0, 6'b000010, 1'b0);
      chk("t5_blocked", {31'd0, IntReq}, 32'd0);
      cyc(5'd12, 5'd0, 32'h0, 1'b0, 32'h3058, 1'b0, 5'd0, 6'b000010, 1'b1);
      rd("t5_sr", 5'd12, 32'h0000_0801);
      chk("t5_req", {31'd0, IntReq}, 32'd1);
      cyc(5'd12, 5'd0, 32'h0, 1'b0, 32'h305C, 1'b0, 5'd0, 6'b000010, 1'b0);

      // register access
      cyc(5'd12, 5'd12, 32'hFFFF_FFFF, 1'b1, 32'h3060, 1'b0, 5'd0, 6'b000000, 1'b0);
      rd("t6_sr", 5'd12, 32'h0000_FC03);
      rd("t6_prid", 5'd15, PRID_C);
      cyc(5'd13, 5'd13, 32'hFFFF_FFFF, 1'b1, 32'h3064, 1'b0, 5'd0, 6'b000000, 1'b0);
      rd("t6_cause", 5'd13, m_cause);
      cyc(5'd14, 5'd14, 32'h0000_1234, 1'b1, 32'h3068, 1'b0, 5'd0, 6'b000000, 1'b0);
      rd("t6_epc_new", 5'd14, 32'h0000_1234);

      // EPC wrap: PC=0 in a delay slot
      cyc(5'd12, 5'd12, 32'h0000_0000, 1'b1, 32'h306C, 1'b0, 5'd0, 6'b000000, 1'b0);
      cyc(5'd14, 5'd0, 32'h0, 1'b0, 32'h0000_0000, 1'b1, 5'd5, 6'b000000, 1'b0);
      rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);

      // randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         cyc(5'($urandom_range(10, 17)), 5'($urandom_range(11, 15)), $urandom,
             1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
             6'($urandom), ($urandom_range(0, 4) == 0));
      end

      // mid-cycle asynchronous reset with EXL=1 and EPC=0x3008
      cyc(5'd12, 5'd12, 32'h0000_0003, 1'b1, 32'h3070, 1'b0, 5'd0, 6'b000000, 1'b0);
      cyc(5'd14, 5'd14, 32'h0000_3008, 1'b1, 32'h3074, 1'b0, 5'd0, 6'b000001, 1'b0);
      rd("pre_rst_epc", 5'd14, 32'h0000_3008);
      rd("pre_rst_sr", 5'd12, 32'h0000_0003);
      clr = 1'b0;
      model_reset();
      #1;
      chk("t1_intreq", {31'd0, IntReq}, 32'd0);
      chk("t1_epcout", EPCOut, 32'h0);
      chk("t1_handler", HandlerPC, HANDLER_C);
      A1 = 5'd12; #1; chk("t1_sr", DOut, 32'h0);
      A1 = 5'd13; #1; chk("t1_cause", DOut, 32'h0);
      @(negedge clk);
      rd("t1_cause_held", 5'd13, 32'h0);
      clr = 1'b1;
      cyc(5'd13, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'b100000, 1'b0);
      rd("ip_after_rst", 5'd13, 32'h0000_8000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
